// File: rtl/m_dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Hits return data one cycle after i_oe; misses stall while the line is fetched from DRAM.
module m_dcache #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_data,
  output logic [31:0]       o_data,
  input  logic [3:0]        i_we,
  input  logic              i_oe,
  output logic              o_stall,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_data,
  input  logic [31:0]       i_mem_data,
  output logic [3:0]        o_mem_we,
  output logic              o_mem_oe,
  input  logic              i_mem_stall,
  output logic [31:0]       o_hit_cnt,
  output logic [31:0]       o_miss_cnt
);

  // state     | meaning
  // IDLE      | serving CPU accesses; stores pass straight through to DRAM
  // FILL_REQ  | presenting the miss address to DRAM until it accepts
  // FILL_WAIT | waiting for DRAM read data, then writing the line
  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - 2;

  typedef enum logic [1:0] {IDLE, FILL_REQ, FILL_WAIT} state_t;

  state_t            state;
  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags  [LINES];
  logic [31:0]       lines [LINES];
  logic [ADDR_W-1:0] r_fill_addr;

  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic [INDEX_W-1:0] fill_index;
  logic [TAG_W-1:0]   fill_tag;
  logic               hit;
  logic               is_store;
  logic               is_load;
  logic               fill_done;

  assign index      = i_addr[INDEX_W+1:2];
  assign tag        = i_addr[ADDR_W-1:INDEX_W+2];
  assign fill_index = r_fill_addr[INDEX_W+1:2];
  assign fill_tag   = r_fill_addr[ADDR_W-1:INDEX_W+2];
  assign hit        = valid[index] && (tags[index] == tag);
  assign is_store   = (state == IDLE) && (i_we != 4'b0000);
  assign is_load    = (state == IDLE) && (i_we == 4'b0000) && i_oe;
  assign fill_done  = (state == FILL_WAIT) && !i_mem_stall;

  assign o_stall = (state != IDLE);

  always_comb begin
    o_mem_addr = i_addr;
    o_mem_data = i_data;
    o_mem_we   = 4'b0000;
    o_mem_oe   = 1'b0;
    case (state)
      IDLE:      o_mem_we = i_we;
      FILL_REQ: begin
        o_mem_addr = r_fill_addr;
        o_mem_oe   = 1'b1;
      end
      FILL_WAIT: o_mem_addr = r_fill_addr;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      valid       <= '0;
      o_data      <= 32'd0;
      o_hit_cnt   <= 32'd0;
      o_miss_cnt  <= 32'd0;
      r_fill_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_load) begin
            if (hit) begin
              o_data    <= lines[index];
              o_hit_cnt <= o_hit_cnt + 32'd1;
            end else begin
              r_fill_addr <= i_addr;
              o_miss_cnt  <= o_miss_cnt + 32'd1;
              state       <= FILL_REQ;
            end
          end
        end
        FILL_REQ: begin
          if (!i_mem_stall) state <= FILL_WAIT;
        end
        FILL_WAIT: begin
          if (!i_mem_stall) begin
            valid[fill_index] <= 1'b1;
            o_data            <= i_mem_data;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage has no reset; a reset cycle suppresses both store merges and fills.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (is_store && hit) begin
        for (int b = 0; b < 4; b++) begin
          if (i_we[b]) lines[index][8*b +: 8] <= i_data[8*b +: 8];
        end
      end else if (fill_done) begin
        tags[fill_index]  <= fill_tag;
        lines[fill_index] <= i_mem_data;
      end
    end
  end

endmodule

// File: tb/tb_m_dcache.sv
// Randomized self-checking bench for m_dcache with a behavioural DRAM and a
// reference model of a direct-mapped, write-through, no-write-allocate cache.
module tb_m_dcache;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_addr, i_data, o_data;
  logic [3:0]  i_we, o_mem_we;
  logic        i_oe, o_stall, o_mem_oe, i_mem_stall;
  logic [31:0] o_mem_addr, o_mem_data, i_mem_data;
  logic [31:0] o_hit_cnt, o_miss_cnt;

  m_dcache dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_addr      (i_addr),
    .i_data      (i_data),
    .o_data      (o_data),
    .i_we        (i_we),
    .i_oe        (i_oe),
    .o_stall     (o_stall),
    .o_mem_addr  (o_mem_addr),
    .o_mem_data  (o_mem_data),
    .i_mem_data  (i_mem_data),
    .o_mem_we    (o_mem_we),
    .o_mem_oe    (o_mem_oe),
    .i_mem_stall (i_mem_stall),
    .o_hit_cnt   (o_hit_cnt),
    .o_miss_cnt  (o_miss_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural DRAM: read accepted when idle, busy for lat cycles; writes immediate.
  logic [31:0] dram [2048];
  int          lat = 16;
  int          busy = 0;
  logic [31:0] rd_addr = 32'd0;

  always @(posedge i_clk) begin
    if (busy > 0) busy <= busy - 1;
    else if (o_mem_oe) begin
      busy    <= lat;
      rd_addr <= o_mem_addr;
    end
    for (int b = 0; b < 4; b++)
      if (o_mem_we[b]) dram[o_mem_addr[12:2]][8*b +: 8] <= o_mem_data[8*b +: 8];
  end

  assign i_mem_stall = (busy != 0);
  assign i_mem_data  = dram[rd_addr[12:2]];

  // Reference model
  logic [31:0] ref_mem [2048];
  bit          m_valid [256];
  int          m_tag   [256];
  int          m_hits = 0, m_misses = 0;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic chk_counts(input string name);
    chk({name, "_hits"}, o_hit_cnt, m_hits);
    chk({name, "_misses"}, o_miss_cnt, m_misses);
  endtask

  task automatic cpu_load(input logic [31:0] a, input bit held);
    int n, w, idx, tg;
    bit exp_hit;
    w   = int'(a[12:2]);
    idx = int'(a[9:2]);
    tg  = int'(a[31:10]);
    exp_hit = m_valid[idx] && (m_tag[idx] == tg);
    i_addr = a; i_oe = 1'b1; i_we = 4'b0000;
    @(posedge i_clk); #1;
    n = 0;
    while (o_stall === 1'b1 && n < 200) begin
      @(posedge i_clk); #1;
      n++;
    end
    i_oe = 1'b0;
    if (exp_hit) m_hits++;
    else begin
      m_misses++;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
    end
    if (held) chk("held_stall_long", (n > 18 && n < 200) ? 32'd1 : 32'd0, 32'd1);
    else      chk("load_stall", n, exp_hit ? 0 : (lat == 0 ? 2 : 18));
    chk("load_data", o_data, ref_mem[w]);
  endtask

  task automatic cpu_store(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] we, input logic oe);
    int w;
    w = int'(a[12:2]);
    i_addr = a; i_data = d; i_we = we; i_oe = oe;
    #1;
    chk("st_mem_we", o_mem_we, we);
    chk("st_mem_addr", o_mem_addr, a);
    chk("st_mem_data", o_mem_data, d);
    chk("st_mem_oe", o_mem_oe, 0);
    chk("st_stall", o_stall, 0);
    @(posedge i_clk); #1;
    i_we = 4'b0000; i_oe = 1'b0;
    for (int b = 0; b < 4; b++)
      if (we[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic random_ops(input int count);
    int r;
    logic [31:0] a;
    for (int k = 0; k < count; k++) begin
      r = $urandom_range(0, 9);
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 2);
      if (r < 5)      cpu_load(a, 1'b0);
      else if (r < 8) cpu_store(a, $urandom, 4'($urandom_range(1, 15)), 1'b0);
      else if (r < 9) cpu_store(a, $urandom, 4'($urandom_range(1, 15)), 1'b1);
      else begin
        @(posedge i_clk); #1;
      end
    end
    chk_counts("random");
  endtask

  initial begin
    int bad;
    i_rst = 1'b1; i_addr = 32'd0; i_data = 32'd0; i_we = 4'b0000; i_oe = 1'b0;
    for (int i = 0; i < 2048; i++) begin
      dram[i]    = (i * 32'h9E3779B9) + 32'h01234567;
      ref_mem[i] = dram[i];
    end
    dram[32'h40]    = 32'hAABBCCDD;
    ref_mem[32'h40] = 32'hAABBCCDD;
    model_reset();

    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    chk("rst_stall", o_stall, 0);
    chk("rst_data", o_data, 0);
    chk("rst_mem_oe", o_mem_oe, 0);
    chk("rst_mem_we", o_mem_we, 0);
    chk_counts("rst");

    // Miss then hit on the same line
    cpu_load(32'h100, 1'b0);
    chk_counts("first_miss");
    cpu_load(32'h100, 1'b0);
    chk_counts("first_hit");

    // Store miss leaves the cache alone, later load misses and sees DRAM
    cpu_store(32'h104, 32'h12345678, 4'b1111, 1'b0);
    cpu_load(32'h104, 1'b0);

    // Byte store into a cached line
    cpu_store(32'h100, 32'h000000EE, 4'b0001, 1'b0);
    cpu_load(32'h100, 1'b0);
    chk("merged_value", o_data, 32'hAABBCCEE);
    chk("dram_merged", dram[32'h40], 32'hAABBCCEE);

    // Index aliasing evicts
    cpu_load(32'h500, 1'b0);
    cpu_load(32'h100, 1'b0);
    chk_counts("evict");

    random_ops(150);

    // Reset during cycle 5 of FILL_WAIT, with DRAM read still in flight
    i_addr = 32'h200; i_oe = 1'b1; i_we = 4'b0000;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    repeat (4) begin
      @(posedge i_clk); #1;
    end
    chk("mid_fill_stall", o_stall, 1);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0; i_oe = 1'b0;
    chk("midrst_stall", o_stall, 0);
    chk("midrst_dram_busy", i_mem_stall, 1);
    model_reset();
    chk_counts("midrst");
    cpu_load(32'h200, 1'b1);
    cpu_load(32'h200, 1'b0);
    chk_counts("after_midrst");

    // NODELAY DRAM
    while (busy != 0) @(posedge i_clk);
    #1;
    lat = 0;
    cpu_load(32'h700, 1'b0);
    cpu_store(32'h700, 32'hCAFEF00D, 4'b1111, 1'b1);
    chk_counts("store_and_oe");
    cpu_load(32'h700, 1'b0);
    chk("store_and_oe_data", o_data, 32'hCAFEF00D);

    random_ops(150);

    bad = 0;
    for (int i = 0; i < 2048; i++) if (dram[i] !== ref_mem[i]) bad++;
    chk("dram_image", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_dcache.md
Name: m_dcache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
- Sits between MIPSCORE's data port (D_ADDR/D_IN/D_OUT/D_OE/D_WE/STALL) and m_pseudo_dram.
- Hides the 16-cycle DRAM read latency on hits.
- Timing on the CPU side matches the NODELAY DRAM: load data is registered one cycle after i_oe, and o_stall is asserted only on a miss.

Parameters:
ADDR_W, 32, width of byte address (matches `ADDR)
INDEX_W, 8, log2 of line count (256 lines × 32 bit)

Ports:
i_clk  in  1  clock; all state updates on posedge
i_rst  in  1  synchronous, active-high reset
i_addr  in  ADDR_W  CPU byte address; word-aligned, [1:0] ignored
i_data  in  32  CPU store data
o_data  out  32  CPU load data, registered
i_we  in  4  CPU byte write enables
i_oe  in  1  CPU load request
o_stall  out  1  CPU stall, combinational from state
o_mem_addr  out  ADDR_W  DRAM address
o_mem_data  out  32  DRAM write data
i_mem_data  in  32  DRAM read data
o_mem_we  out  4  DRAM byte write enables
o_mem_oe  out  1  DRAM read request
i_mem_stall  in  1  DRAM busy
o_hit_cnt  out  32  load hits since reset
o_miss_cnt  out  32  load misses since reset

Behaviour:
- Address split:
  - index = i_addr[INDEX_W+1:2]
  - tag = i_addr[ADDR_W-1:INDEX_W+2]
- Per line: valid bit, tag, 32-bit data.
- Reset values:
  - state = IDLE; all valid bits = 0.
  - o_data = 0, o_stall = 0, o_mem_oe = 0, o_mem_we = 0.
  - o_hit_cnt = 0, o_miss_cnt = 0.
  - Reset mid-fill abandons the fill; no line is written.
- o_stall = (state != IDLE).
- States: IDLE, FILL_REQ, FILL_WAIT.
- IDLE, store (i_we != 0):
  - Combinationally drive o_mem_addr = i_addr, o_mem_data = i_data, o_mem_we = i_we. No stall.
  - On a hit, merge the enabled bytes into the line at posedge. On a miss, the cache is unchanged.
  - If i_oe is also asserted, the store wins and i_oe is ignored that cycle.
- IDLE, load (i_oe = 1, i_we = 0):
  - Hit (valid && tag match): o_data <= line data at posedge, o_hit_cnt += 1, stay in IDLE.
  - Miss: latch i_addr into r_fill_addr, o_miss_cnt += 1, go to FILL_REQ. o_data is unchanged.
- IDLE, otherwise: o_mem_we = 0, o_mem_oe = 0, o_mem_addr = i_addr.
- FILL_REQ:
  - o_mem_addr = r_fill_addr, o_mem_oe = 1, o_mem_we = 0.
  - If i_mem_stall = 0, go to FILL_WAIT at posedge; otherwise hold.
  - Holding covers a DRAM read still in flight from before a reset.
- FILL_WAIT:
  - o_mem_oe = 0, o_mem_addr = r_fill_addr.
  - When i_mem_stall = 0: write the line (valid = 1, tag, data = i_mem_data), set o_data <= i_mem_data, go to IDLE.
  - This works for both DRAM variants. With the delayed DRAM, stall is 1 in the first FILL_WAIT cycle and the data is valid when stall falls. With NODELAY, the data is valid in the first FILL_WAIT cycle.
- CPU inputs are ignored outside IDLE; the core holds them while stalled. o_mem_we is 0 outside IDLE.
- Miss latency with the delayed DRAM: o_stall is high for 18 cycles (FILL_REQ 1 + FILL_WAIT 17). With NODELAY: 2 cycles.
- Counters wrap modulo 2^32.
- Index aliasing: a load to a different tag at the same index evicts the line.

Test Plan:
1. Reset, then load 0x100 → o_stall high 18 cycles, o_data = DRAM[0x40] on release, o_miss_cnt = 1. Repeat load 0x100 → no stall, data next cycle, o_hit_cnt = 1.
2. Store 0x12345678 to 0x104 with i_we = 4'b1111 (miss) → o_mem_we = 4'hf in the same cycle, no stall, cache line unchanged. Then load 0x104 → miss, returns 0x12345678.
3. After line 0x100 = 0xAABBCCDD is cached, store 0x000000EE with i_we = 4'b0001 → the following load hits and returns 0xAABBCCEE; DRAM also updated.
4. Load 0x100, then load 0x100 + (1 << (INDEX_W+2)) = 0x500 → both miss, 0x500 evicts 0x100, and the next load 0x100 misses again (o_miss_cnt = 3).
5. Assert i_rst in cycle 5 of a FILL_WAIT → next cycle IDLE, o_stall = 0, counters 0. A new load holds FILL_REQ until i_mem_stall falls, then completes with correct data.
6. NODELAY DRAM: load miss → o_stall high exactly 2 cycles; simultaneous i_oe and i_we → store only, no counter increment.
